// File: rtl/bayer_stream_tx_if.sv
// Memory read port plus tagged pixel stream of the Bayer frame source.
// Ports: mem_re_o/mem_addr_o/mem_data_i (synchronous single-port frame memory),
//        pixel_out/valid_out/color_out/last_col_out/last_pic_out (ISP input stream).
interface bayer_stream_tx_if #(
  parameter int ADDR_W      = 12,
  parameter int COLOR_DEPTH = 8
);
  // frame memory read port
  logic                   mem_re_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [COLOR_DEPTH-1:0] mem_data_i;

  // pixel stream toward the ISP top
  logic [COLOR_DEPTH-1:0] pixel_out;
  logic                   valid_out;
  logic [1:0]             color_out;
  logic                   last_col_out;
  logic                   last_pic_out;

  // frame source side: drives the read port and the stream
  modport master (
    output mem_re_o,
    output mem_addr_o,
    input  mem_data_i,
    output pixel_out,
    output valid_out,
    output color_out,
    output last_col_out,
    output last_pic_out
  );

  // memory + consumer side
  modport slave (
    input  mem_re_o,
    input  mem_addr_o,
    output mem_data_i,
    input  pixel_out,
    input  valid_out,
    input  color_out,
    input  last_col_out,
    input  last_pic_out
  );
endinterface

// File: rtl/bayer_stream_tx.sv
// Bayer frame source: reads one raw frame row-major from a synchronous frame
// memory and emits it as a tagged pixel stream (color, last_col, last_pic).
// Ports: clk, rst (async active-high), start_i/mode_i (frame start + mode),
//        pause_i (read pacing stall), bus (memory port + pixel stream),
//        mode_out (latched mode), busy_o, done_o (one-cycle end-of-frame pulse).
// Latency: read issued in cycle t shows on the stream in cycle t+2.
module bayer_stream_tx #(
  parameter int IMG_W        = 64,
  parameter int IMG_H        = 64,
  parameter int ADDR_W       = 12,
  parameter int COLOR_DEPTH  = 8,
  parameter int MODE_BIT_CNT = 3,
  parameter int BAYER        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [MODE_BIT_CNT-1:0] mode_i,
  input  logic                    pause_i,
  bayer_stream_tx_if.master       bus,
  output logic [MODE_BIT_CNT-1:0] mode_out,
  output logic                    busy_o,
  output logic                    done_o
);

  // Counter widths; a 1-wide dimension still needs a 1-bit counter.
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [1:0]    CFA      = 2'(BAYER);

  localparam logic [1:0] C_RED   = 2'd0;
  localparam logic [1:0] C_GREEN = 2'd1;
  localparam logic [1:0] C_BLUE  = 2'd2;
  localparam logic [1:0] C_VOID  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  logic              drain_cnt;

  // Read-issue register: read strobe/address and the tags of that pixel.
  logic              rd_re;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_color;
  logic              rd_lcol;
  logic              rd_lpic;

  // Tags of the read whose data arrives on mem_data_i this cycle.
  logic              s1_vld;
  logic [1:0]        s1_color;
  logic              s1_lcol;
  logic              s1_lpic;

  // Stream output registers.
  logic [COLOR_DEPTH-1:0] pix_q;
  logic                   vld_q;
  logic [1:0]             color_q;
  logic                   lcol_q;
  logic                   lpic_q;

  logic       at_col_end;
  logic       at_row_end;
  logic       at_frame_end;
  logic [1:0] cfa_p;
  logic [1:0] cur_color;

  assign at_col_end   = (col == COL_LAST);
  assign at_row_end   = (row == ROW_LAST);
  assign at_frame_end = at_col_end && at_row_end;

  // CFA phase of the current pixel; the BAYER order just flips row/col parity.
  assign cfa_p = {row[0] ^ CFA[1], col[0] ^ CFA[0]};

  always_comb begin
    cur_color = C_GREEN;
    case (cfa_p)
      2'b00:   cur_color = C_RED;
      2'b11:   cur_color = C_BLUE;
      default: cur_color = C_GREEN;
    endcase
  end

  // Control FSM and read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      drain_cnt <= 1'b0;
      rd_re     <= 1'b0;
      rd_addr   <= '0;
      rd_color  <= C_VOID;
      rd_lcol   <= 1'b0;
      rd_lpic   <= 1'b0;
      mode_out  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      rd_re  <= 1'b0;
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode_out <= mode_i;
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            busy_o   <= 1'b1;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (!pause_i) begin
            rd_re    <= 1'b1;
            rd_addr  <= addr;
            rd_color <= cur_color;
            rd_lcol  <= at_col_end;
            rd_lpic  <= at_frame_end;
            if (at_frame_end) begin
              // Counters stop on the final pixel so the address never
              // runs past the frame.
              drain_cnt <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (at_col_end) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end

        // Two cycles for the last read to pass both pipeline stages.
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: tags ride one register behind the read strobe so they
  // line up with mem_data_i, then join the data in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_color <= C_VOID;
      s1_lcol  <= 1'b0;
      s1_lpic  <= 1'b0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      color_q  <= C_VOID;
      lcol_q   <= 1'b0;
      lpic_q   <= 1'b0;
    end else begin
      s1_vld   <= rd_re;
      s1_color <= rd_color;
      s1_lcol  <= rd_lcol;
      s1_lpic  <= rd_lpic;

      vld_q <= s1_vld;
      if (s1_vld) begin
        pix_q   <= bus.mem_data_i;
        color_q <= s1_color;
        lcol_q  <= s1_lcol;
        lpic_q  <= s1_lpic;
      end else begin
        // bubble: tags cleared, pixel value held
        color_q <= C_VOID;
        lcol_q  <= 1'b0;
        lpic_q  <= 1'b0;
      end
    end
  end

  assign bus.mem_re_o     = rd_re;
  assign bus.mem_addr_o   = rd_addr;
  assign bus.pixel_out    = pix_q;
  assign bus.valid_out    = vld_q;
  assign bus.color_out    = color_q;
  assign bus.last_col_out = lcol_q;
  assign bus.last_pic_out = lpic_q;

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Bench for bayer_stream_tx: three instances (4x2 RGGB, 1x1 RGGB, 4x2 BGGR),
// each with a memory model returning addr+10 one cycle after a read.
module tb_bayer_stream_tx;
  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;
  localparam int V = 3;

  typedef struct {
    logic        start;
    logic        pause;
    logic        re;
    logic [11:0] addr;
    logic        vld;
    logic [7:0]  pix;
    logic [1:0]  col;
    logic        lc;
    logic        lp;
    logic        busy;
    logic        done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [3];
  logic       pause_s [3];
  logic [2:0] mode_in [3];
  logic [2:0] mode_s  [3];
  logic       busy_s  [3];
  logic       done_s  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bayer_stream_tx_if #(.ADDR_W(12), .COLOR_DEPTH(8)) bA ();
  bayer_stream_tx_if #(.ADDR_W(12), .COLOR_DEPTH(8)) bB ();
  bayer_stream_tx_if #(.ADDR_W(12), .COLOR_DEPTH(8)) bC ();

  bayer_stream_tx #(.IMG_W(4), .IMG_H(2), .ADDR_W(12), .COLOR_DEPTH(8),
                    .MODE_BIT_CNT(3), .BAYER(0)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .mode_i(mode_in[0]),
    .pause_i(pause_s[0]), .bus(bA), .mode_out(mode_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]));

  bayer_stream_tx #(.IMG_W(1), .IMG_H(1), .ADDR_W(12), .COLOR_DEPTH(8),
                    .MODE_BIT_CNT(3), .BAYER(0)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .mode_i(mode_in[1]),
    .pause_i(pause_s[1]), .bus(bB), .mode_out(mode_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]));

  bayer_stream_tx #(.IMG_W(4), .IMG_H(2), .ADDR_W(12), .COLOR_DEPTH(8),
                    .MODE_BIT_CNT(3), .BAYER(3)) dut_c (
    .clk(clk), .rst(rst), .start_i(start_s[2]), .mode_i(mode_in[2]),
    .pause_i(pause_s[2]), .bus(bC), .mode_out(mode_s[2]),
    .busy_o(busy_s[2]), .done_o(done_s[2]));

  // frame memories: mem[i] = i + 10, synchronous read
  always_ff @(posedge clk) if (bA.mem_re_o) bA.mem_data_i <= 8'(bA.mem_addr_o + 12'd10);
  always_ff @(posedge clk) if (bB.mem_re_o) bB.mem_data_i <= 8'(bB.mem_addr_o + 12'd10);
  always_ff @(posedge clk) if (bC.mem_re_o) bC.mem_data_i <= 8'(bC.mem_addr_o + 12'd10);

  function automatic vec_t mk(bit st, bit pa, bit re, int a, bit vld, int pix,
                              int col, bit lc, bit lp, bit busy, bit done);
    vec_t v;
    v.start = st;  v.pause = pa;  v.re = re;  v.addr = 12'(a);
    v.vld = vld;   v.pix = 8'(pix); v.col = 2'(col);
    v.lc = lc;     v.lp = lp;     v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int d, output vec_t o);
    o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (d)
      0: begin
        o.re = bA.mem_re_o; o.addr = bA.mem_addr_o; o.vld = bA.valid_out;
        o.pix = bA.pixel_out; o.col = bA.color_out; o.lc = bA.last_col_out;
        o.lp = bA.last_pic_out;
      end
      1: begin
        o.re = bB.mem_re_o; o.addr = bB.mem_addr_o; o.vld = bB.valid_out;
        o.pix = bB.pixel_out; o.col = bB.color_out; o.lc = bB.last_col_out;
        o.lp = bB.last_pic_out;
      end
      default: begin
        o.re = bC.mem_re_o; o.addr = bC.mem_addr_o; o.vld = bC.valid_out;
        o.pix = bC.pixel_out; o.col = bC.color_out; o.lc = bC.last_col_out;
        o.lp = bC.last_pic_out;
      end
    endcase
    o.busy = busy_s[d];
    o.done = done_s[d];
  endtask

  // One table row: drive inputs, clock once, compare every output field.
  task automatic apply(input int d, input vec_t v, input bit swap,
                       input string nm, input int stp);
    vec_t o;
    logic [1:0] ec;
    start_s[d] = v.start;
    pause_s[d] = v.pause;
    step();
    sample(d, o);
    ec = v.col;
    if (swap && v.col != 2'd3) ec = 2'(2 - int'(v.col));
    chk({nm, ".re"}, stp, 32'(o.re), 32'(v.re));
    if (v.re) chk({nm, ".addr"}, stp, 32'(o.addr), 32'(v.addr));
    chk({nm, ".valid"}, stp, 32'(o.vld), 32'(v.vld));
    chk({nm, ".pixel"}, stp, 32'(o.pix), 32'(v.pix));
    chk({nm, ".color"}, stp, 32'(o.col), 32'(ec));
    chk({nm, ".last_col"}, stp, 32'(o.lc), 32'(v.lc));
    chk({nm, ".last_pic"}, stp, 32'(o.lp), 32'(v.lp));
    chk({nm, ".busy"}, stp, 32'(o.busy), 32'(v.busy));
    chk({nm, ".done"}, stp, 32'(o.done), 32'(v.done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t_nopause[$];
    vec_t t_pause[$];
    vec_t t_one[$];
    vec_t o;
    int   nvld;
    int   ndone;
    bit   found;

    // 4x2 frame, no pause (RGGB colors; BGGR instance swaps R/B)
    t_nopause.push_back(mk(1,0, 0,0, 0, 0,V,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,0, 0, 0,V,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,1, 0, 0,V,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,2, 1,10,R,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,3, 1,11,G,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,4, 1,12,R,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,5, 1,13,G,1,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,6, 1,14,G,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 1,7, 1,15,B,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 0,0, 1,16,G,0,0, 1,0));
    t_nopause.push_back(mk(0,0, 0,0, 1,17,B,1,1, 1,0));
    t_nopause.push_back(mk(0,0, 0,0, 0,17,V,0,0, 0,1));
    t_nopause.push_back(mk(0,0, 0,0, 0,17,V,0,0, 0,0));

    // same frame, 3 paused cycles after addr 2; pause during drain is ignored
    t_pause.push_back(mk(1,0, 0,0, 0,17,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,0, 0,17,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,1, 0,17,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,2, 1,10,R,0,0, 1,0));
    t_pause.push_back(mk(0,1, 0,0, 1,11,G,0,0, 1,0));
    t_pause.push_back(mk(0,1, 0,0, 1,12,R,0,0, 1,0));
    t_pause.push_back(mk(0,1, 0,0, 0,12,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,3, 0,12,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,4, 0,12,V,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,5, 1,13,G,1,0, 1,0));
    t_pause.push_back(mk(0,0, 1,6, 1,14,G,0,0, 1,0));
    t_pause.push_back(mk(0,0, 1,7, 1,15,B,0,0, 1,0));
    t_pause.push_back(mk(0,1, 0,0, 1,16,G,0,0, 1,0));
    t_pause.push_back(mk(0,1, 0,0, 1,17,B,1,1, 1,0));
    t_pause.push_back(mk(0,0, 0,0, 0,17,V,0,0, 0,1));

    // 1x1 frame
    t_one.push_back(mk(1,0, 0,0, 0, 0,V,0,0, 1,0));
    t_one.push_back(mk(0,0, 1,0, 0, 0,V,0,0, 1,0));
    t_one.push_back(mk(0,0, 0,0, 0, 0,V,0,0, 1,0));
    t_one.push_back(mk(0,0, 0,0, 1,10,R,1,1, 1,0));
    t_one.push_back(mk(0,0, 0,0, 0,10,V,0,0, 0,1));
    t_one.push_back(mk(0,0, 0,0, 0,10,V,0,0, 0,0));

    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      pause_s[i] = 1'b0;
      mode_in[i] = 3'd0;
    end
    rst = 1'b1;

    // reset values without any clock edge
    #3;
    sample(0, o);
    chk("rst.re", 0, 32'(o.re), 32'd0);
    chk("rst.addr", 0, 32'(o.addr), 32'd0);
    chk("rst.valid", 0, 32'(o.vld), 32'd0);
    chk("rst.pixel", 0, 32'(o.pix), 32'd0);
    chk("rst.color", 0, 32'(o.col), 32'd3);
    chk("rst.last", 0, 32'({o.lc, o.lp}), 32'd0);
    chk("rst.busy_done", 0, 32'({busy_s[0], done_s[0]}), 32'd0);
    chk("rst.mode", 0, 32'(mode_s[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (t_nopause[i]) apply(0, t_nopause[i], 1'b0, "rggb", i);
    foreach (t_nopause[i]) apply(2, t_nopause[i], 1'b1, "bggr", i);
    foreach (t_one[i])     apply(1, t_one[i], 1'b0, "one_px", i);
    foreach (t_pause[i])   apply(0, t_pause[i], 1'b0, "pause", i);

    // start ignored mid-frame; mode held at the first value
    start_s[0] = 1'b1;
    mode_in[0] = 3'd5;
    step();
    chk("mode.first", 0, 32'(mode_s[0]), 32'd5);
    nvld = 0;
    ndone = 0;
    for (int i = 1; i <= 16; i++) begin
      start_s[0] = (i == 3);
      mode_in[0] = 3'd2;
      step();
      if (bA.valid_out) nvld++;
      if (done_s[0]) ndone++;
      chk("mode.hold", i, 32'(mode_s[0]), 32'd5);
    end
    start_s[0] = 1'b0;
    chk("mode.valid_count", 0, 32'(nvld), 32'd8);
    chk("mode.done_count", 0, 32'(ndone), 32'd1);

    // reset mid-frame at pixel 4
    start_s[0] = 1'b1;
    mode_in[0] = 3'd6;
    step();
    start_s[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bA.valid_out === 1'b1 && bA.pixel_out === 8'd14) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort.reach_px4", 0, 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    sample(0, o);
    chk("abort.valid", 0, 32'(o.vld), 32'd0);
    chk("abort.pixel", 0, 32'(o.pix), 32'd0);
    chk("abort.color", 0, 32'(o.col), 32'd3);
    chk("abort.last", 0, 32'({o.lc, o.lp}), 32'd0);
    chk("abort.re_addr", 0, 32'({o.re, o.addr}), 32'd0);
    chk("abort.busy_done", 0, 32'({busy_s[0], done_s[0]}), 32'd0);
    chk("abort.mode", 0, 32'(mode_s[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort.quiet", i, 32'({done_s[0], bA.valid_out, busy_s[0]}), 32'd0);
    end
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    chk("restart.busy", 0, 32'(busy_s[0]), 32'd1);
    step();
    chk("restart.re", 1, 32'(bA.mem_re_o), 32'd1);
    chk("restart.addr", 1, 32'(bA.mem_addr_o), 32'd0);
    step();
    step();
    chk("restart.valid", 3, 32'(bA.valid_out), 32'd1);
    chk("restart.pixel", 3, 32'(bA.pixel_out), 32'd10);
    for (int i = 0; i < 12; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
